// File: rtl/pico_mem_pkg.sv
// Shared constants, types and decode helpers for the picorv32 memory bridge.
package pico_mem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned WAIT_W = 4;
    localparam int unsigned OFS_W  = 6;

    localparam logic [ADDR_W-1:0] RAM_BASE  = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] MMIO_BASE = 32'h1000_0000;

    localparam logic [OFS_W-1:0] OFS_GPIO   = 6'd0;
    localparam logic [OFS_W-1:0] OFS_CYCLE  = 6'd1;
    localparam logic [OFS_W-1:0] OFS_STATUS = 6'd2;

    localparam logic [DATA_W-1:0] UNMAPPED_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MMIO,
        REG_NONE
    } region_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
        region_e           region;
    } mem_req_t;

    // RAM needs every bit above the word index clear; MMIO is a 256-byte window.
    function automatic region_e decode_region(input logic [ADDR_W-1:0] addr,
                                              input int unsigned       ram_aw);
        logic [ADDR_W-1:0] ram_ofs;
        ram_ofs = addr - RAM_BASE;
        if ((ram_ofs >> (ram_aw + 2)) == '0) begin
            return REG_RAM;
        end
        if (addr[ADDR_W-1:8] == MMIO_BASE[ADDR_W-1:8]) begin
            return REG_MMIO;
        end
        return REG_NONE;
    endfunction

    function automatic logic [DATA_W-1:0] lane_mask(input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int b = 0; b < int'(STRB_W); b++) begin
            m[8*b +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/pico_bram_sp.sv
// Single-port RAM with byte enables and registered read-first output.
module pico_bram_sp
    import pico_mem_pkg::*;
#(
    parameter int unsigned AW = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic [STRB_W-1:0] we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Contents are intentionally not reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata_q <= mem_q[addr];
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (we[b]) begin
                    mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pico_mem_bridge.sv
// Responder for the picorv32 native memory bus: word RAM, MMIO registers and
// a sticky error for unmapped accesses, with optional wait states.
module pico_mem_bridge
    import pico_mem_pkg::*;
#(
    parameter int unsigned RAM_AW      = 10,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned GPIO_W      = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_valid,
    input  logic              mem_instr,
    output logic              mem_ready,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_rdata,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              bus_err
);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    mem_req_t          req_q, req_d;
    mem_req_t          req_live_c, req_eff_c;
    logic [DATA_W-1:0] cyc_q, cyc_d;
    logic [DATA_W-1:0] cyc_lat_q, cyc_lat_d;
    logic [DATA_W-1:0] cyc_eff_c;
    logic              ready_q, ready_d;
    logic              commit_c;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rd_ram_q, rd_ram_d;
    logic [GPIO_W-1:0] gpio_q, gpio_d;
    logic              err_q, err_d;
    logic              instr_q, instr_d;

    logic [OFS_W-1:0]  ofs_c;
    logic [DATA_W-1:0] gpio_wr_c;
    logic [DATA_W-1:0] wmask_c;
    logic              ram_en_c;
    logic [STRB_W-1:0] ram_we_c;
    logic [DATA_W-1:0] ram_rdata;
    logic              unused_c;

    always_comb begin
        req_live_c.addr   = mem_addr;
        req_live_c.wdata  = mem_wdata;
        req_live_c.wstrb  = mem_wstrb;
        req_live_c.region = decode_region(mem_addr, RAM_AW);
    end

    // With zero wait states the commit edge is the accept edge, so live inputs are used.
    assign req_eff_c = (state_q == ST_IDLE) ? req_live_c : req_q;
    assign cyc_eff_c = (state_q == ST_IDLE) ? cyc_q : cyc_lat_q;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        req_d      = req_q;
        cyc_lat_d  = cyc_lat_q;
        instr_d    = instr_q;
        commit_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_valid) begin
                    req_d     = req_live_c;
                    cyc_lat_d = cyc_q;
                    instr_d   = mem_instr;
                    if (WAIT_STATES == 0) begin
                        state_d  = ST_RESP;
                        commit_c = 1'b1;
                    end else begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WAIT_W'(WAIT_STATES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d  = ST_RESP;
                    commit_c = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = commit_c;
    end

    always_comb begin
        ofs_c     = req_eff_c.addr[7:2];
        wmask_c   = lane_mask(req_eff_c.wstrb);
        gpio_wr_c = (DATA_W'(gpio_q) & ~wmask_c) | (req_eff_c.wdata & wmask_c);
        ram_en_c  = commit_c && (req_eff_c.region == REG_RAM);
        ram_we_c  = ram_en_c ? req_eff_c.wstrb : '0;
    end

    // MMIO and error side effects, all applied on the edge entering RESP.
    always_comb begin
        cyc_d    = cyc_q + DATA_W'(1);
        gpio_d   = gpio_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        rd_ram_d = rd_ram_q;
        if (commit_c) begin
            rd_ram_d = 1'b0;
            case (req_eff_c.region)
                REG_RAM: begin
                    rd_ram_d = 1'b1;
                end
                REG_MMIO: begin
                    case (ofs_c)
                        OFS_GPIO: begin
                            rdata_d = DATA_W'(gpio_q);
                            gpio_d  = GPIO_W'(gpio_wr_c);
                        end
                        OFS_CYCLE: begin
                            rdata_d = cyc_eff_c;
                        end
                        OFS_STATUS: begin
                            rdata_d = DATA_W'(err_q);
                            if (req_eff_c.wstrb[0] && req_eff_c.wdata[0]) begin
                                err_d = 1'b0;
                            end
                        end
                        default: begin
                            rdata_d = UNMAPPED_RDATA;
                            err_d   = 1'b1;
                        end
                    endcase
                end
                default: begin
                    rdata_d = UNMAPPED_RDATA;
                    err_d   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            req_q      <= '0;
            cyc_q      <= '0;
            cyc_lat_q  <= '0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            rd_ram_q   <= 1'b0;
            gpio_q     <= '0;
            err_q      <= 1'b0;
            instr_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            req_q      <= req_d;
            cyc_q      <= cyc_d;
            cyc_lat_q  <= cyc_lat_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            rd_ram_q   <= rd_ram_d;
            gpio_q     <= gpio_d;
            err_q      <= err_d;
            instr_q    <= instr_d;
        end
    end

    pico_bram_sp #(
        .AW(RAM_AW)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en_c),
        .we   (ram_we_c),
        .addr (req_eff_c.addr[RAM_AW+1:2]),
        .wdata(req_eff_c.wdata),
        .rdata(ram_rdata)
    );

    // RAM reads are served straight from the RAM output register, which only
    // changes on a RAM commit, so the selected value holds outside RESP.
    assign mem_rdata = rd_ram_q ? ram_rdata : rdata_q;
    assign mem_ready = ready_q;
    assign gpio_out  = gpio_q;
    assign bus_err   = err_q;

    // Fetch flag and byte-offset address bits are kept for debug visibility only.
    assign unused_c = ^{instr_q, req_eff_c.addr};

endmodule
